// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and edge-detect five push buttons
//
// Purpose: front end for set_time. Each raw button bit is synchronised by a
// two-flop chain, debounced by a per-bit stable-cycle counter, and turned into
// a clean level plus one-cycle press and release pulses.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_raw[4:0] raw buttons, [0]=mid [1]=l [2]=r [3]=up [4]=down, active-high
//   btn_level    debounced level per button
//   btn_pulse    one-cycle pulse when a level rises (plus repeats, see below)
//   btn_release  one-cycle pulse when a level falls
//
// Optional feature: define BTN_AUTOREPEAT_EN to give up/down (bits 3 and 4)
// auto-repeat press pulses while held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic [4:0] btn_release
);

    // Reject illegal parameter sets at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD >= REPEAT_DELAY) begin : g_param_check
        $error("button_conditioner: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       sync1_q, sync2_q;
    logic [4:0]       level_q, level_d;
    logic [4:0]       pulse_q, pulse_d;
    logic [4:0]       release_q, release_d;
    logic [4:0]       rise, fall;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       repeat_fire;

    // Debounce: the counter only runs while the synchronised input disagrees
    // with the accepted level; any agreement restarts it from zero.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_FIRE_AT = RW'(REPEAT_DELAY - 2);
    localparam logic [RW-1:0] REP_RELOAD  = RW'(REPEAT_DELAY - 1 - REPEAT_PERIOD);

    logic [RW-1:0] rep_q [2];
    logic [RW-1:0] rep_d [2];

    // The counter value after this edge equals the number of cycles held
    // since the press pulse; a repeat fires as that value reaches
    // REPEAT_DELAY-1 and the counter reloads so the next fires one period on.
    always_comb begin
        repeat_fire = '0;
        for (int j = 0; j < 2; j++) begin
            rep_d[j] = '0;
            if (level_d[3+j] && !rise[3+j]) begin
                if (rep_q[j] == REP_FIRE_AT) begin
                    rep_d[j]         = REP_RELOAD;
                    repeat_fire[3+j] = 1'b1;
                end else begin
                    rep_d[j] = rep_q[j] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q[0] <= '0;
            rep_q[1] <= '0;
        end else begin
            rep_q[0] <= rep_d[0];
            rep_q[1] <= rep_d[1];
        end
    end
`else
    assign repeat_fire = '0;
`endif

    assign pulse_d   = rise | repeat_fire;
    assign release_d = fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            pulse_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

    localparam int DB  = 4;
    localparam int LAT = DB + 2;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic [4:0] btn_release;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (3),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .btn_release(btn_release)
    );

    typedef struct {
        int         cyc;
        logic [4:0] p;
        logic [4:0] r;
    } ev_t;

    ev_t        sb[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] lvl_exp = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic expect_ev(input int c, input logic [4:0] p, input logic [4:0] r);
        ev_t e;
        e.cyc = c;
        e.p   = p;
        e.r   = r;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every cycle: anything due this cycle is popped from the scoreboard;
    // with nothing due, both pulse outputs must be zero.
    always @(negedge clk) begin
        logic [4:0] exp_p;
        logic [4:0] exp_r;
        exp_p = '0;
        exp_r = '0;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_p = exp_p | sb[0].p;
            exp_r = exp_r | sb[0].r;
            void'(sb.pop_front());
        end
        lvl_exp = (lvl_exp | exp_p) & ~exp_r;
        checks++;
        assert (btn_pulse === exp_p) else begin
            errors++;
            $error("FAIL pulse cyc=%0d observed=%b expected=%b", cyc, btn_pulse, exp_p);
        end
        checks++;
        assert (btn_release === exp_r) else begin
            errors++;
            $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, btn_release, exp_r);
        end
        checks++;
        assert (btn_level === lvl_exp) else begin
            errors++;
            $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, btn_level, lvl_exp);
        end
    end

    initial begin
        int a;
        rst_n   = 1'b0;
        btn_raw = 5'b11111;

        // Reset with all buttons held, then release: one press on every bit.
        tick(3);
        rst_n = 1'b1;
        expect_ev(cyc + LAT, 5'b11111, 5'b00000);
        tick(12);
        btn_raw = 5'b00000;
        expect_ev(cyc + LAT, 5'b00000, 5'b11111);
        tick(12);

        // Clean press and release of r.
        btn_raw[2] = 1'b1;
        expect_ev(cyc + LAT, 5'b00100, 5'b00000);
        tick(20);
        btn_raw[2] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00100);
        tick(12);

        // Bounce on l, then a steady hold.
        for (int k = 0; k < 8; k++) begin
            btn_raw[1] = (k % 2 == 0);
            tick(1);
        end
        btn_raw[1] = 1'b1;
        expect_ev(cyc + LAT, 5'b00010, 5'b00000);
        tick(12);
        btn_raw[1] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00010);
        tick(12);

        // Glitch of DEBOUNCE_CYCLES-1 cycles on mid: nothing expected.
        btn_raw[0] = 1'b1;
        tick(DB - 1);
        btn_raw[0] = 1'b0;
        tick(12);

        // Up and down together, held long enough to exercise auto-repeat.
        btn_raw[4:3] = 2'b11;
        a = cyc + LAT;
        expect_ev(a, 5'b11000, 5'b00000);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 9; k < 30; k += 3) begin
            expect_ev(a + k, 5'b11000, 5'b00000);
        end
`endif
        tick(30);
        btn_raw[4:3] = 2'b00;
        expect_ev(cyc + LAT, 5'b00000, 5'b11000);
        tick(15);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
